// File: rtl/board_spi_master.sv
// board_spi_master: streams an N*N byte board over SPI, MSB first,
// and captures the first sdo byte of every frame as a key.
module board_spi_master #(
  parameter int N    = 32,
  parameter int HALF = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [$clog2(N*N)-1:0]   rd_addr,
  input  logic [7:0]               rd_data,
  output logic                     sclk,
  output logic                     cs,
  output logic                     load,
  output logic                     sdi,
  input  logic                     sdo,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               key_byte,
  output logic                     key_valid
);

  localparam int AW = $clog2(N*N);
  localparam logic [AW-1:0] LAST  = AW'(N*N-1);
  localparam logic [AW-1:0] ONE   = AW'(1);
  localparam logic [7:0]    HLAST = 8'(HALF-1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    GUARD,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    hcnt_q;
  logic          sclk_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [AW-1:0] byte_q;
  logic [AW-1:0] addr_q;
  logic [6:0]    ksh_q;
  logic [3:0]    kcnt_q;
  logic [7:0]    key_q;
  logic          kv_q;

  logic half_end;
  logic rise;
  logic fall;
  logic last_byte;
  logic last_bit;

  assign half_end  = (hcnt_q == HLAST);
  assign rise      = (state_q == SHIFT) && half_end && !sclk_q;
  assign fall      = (state_q == SHIFT) && half_end && sclk_q;
  assign last_byte = (byte_q == LAST);
  assign last_bit  = (bit_q == 3'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cs      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    sdi     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        cs      = 1'b1;
        busy    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        cs   = 1'b1;
        busy = 1'b1;
        sdi  = shift_q[7];
        if (fall && last_bit && last_byte)
          state_d = GUARD;
      end
      GUARD: begin
        cs   = 1'b1;
        busy = 1'b1;
        if (half_end) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load      = cs;
  assign sclk      = sclk_q;
  assign rd_addr   = addr_q;
  assign key_byte  = key_q;
  assign key_valid = kv_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hcnt_q  <= '0;
      sclk_q  <= 1'b0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      addr_q  <= '0;
      ksh_q   <= '0;
      kcnt_q  <= '0;
      key_q   <= '0;
      kv_q    <= 1'b0;
    end else begin
      kv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          hcnt_q <= '0;
          sclk_q <= 1'b0;
        end
        FETCH: begin
          shift_q <= rd_data;
          bit_q   <= 3'd7;
          hcnt_q  <= '0;
          sclk_q  <= 1'b0;
          byte_q  <= '0;
          kcnt_q  <= '0;
        end
        SHIFT: begin
          if (half_end) begin
            hcnt_q <= '0;
            sclk_q <= !sclk_q;
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
          if (rise) begin
            if (kcnt_q != 4'd8) begin
              ksh_q  <= {ksh_q[5:0], sdo};
              kcnt_q <= kcnt_q + 4'd1;
              if (kcnt_q == 4'd7) begin
                key_q <= {ksh_q, sdo};
                kv_q  <= 1'b1;
              end
            end
            // prefetch so the next byte is ready at this bit's falling edge
            if (last_bit && !last_byte)
              addr_q <= addr_q + ONE;
          end
          if (fall) begin
            if (last_bit) begin
              shift_q <= rd_data;
              bit_q   <= 3'd7;
              if (!last_byte) byte_q <= byte_q + ONE;
            end else begin
              shift_q <= {shift_q[6:0], 1'b0};
              bit_q   <= bit_q - 3'd1;
            end
          end
        end
        GUARD: begin
          sclk_q <= 1'b0;
          if (!half_end) hcnt_q <= hcnt_q + 8'd1;
        end
        DONE: begin
          hcnt_q <= '0;
          addr_q <= '0;
          byte_q <= '0;
        end
        default: begin
          hcnt_q <= '0;
          sclk_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
